// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end with single-outstanding ROM handshake, skid buffer and redirects
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);
  typedef enum logic [1:0] {IDLE, REQ, BUF, DROP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pend_pc, pend_pc_n, buf_pc, buf_pc_n, if_pc_n;
  logic [DATA_W-1:0] buf_inst, buf_inst_n, if_inst_n;
  logic pend_v, pend_v_n, if_valid_n, ack, bubble;
  assign rom_req = state == REQ || state == DROP;
  assign rom_addr = pc;
  assign ack = rom_req && rom_ack;
  // next-state and next-output logic; flush outranks branch and stall
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_pc_n = pend_pc;
    pend_v_n = pend_v;
    buf_pc_n = buf_pc;
    buf_inst_n = buf_inst;
    if_pc_n = if_pc;
    if_inst_n = if_inst;
    if_valid_n = if_valid;
    bubble = 1'b0;
    if (flush_i) begin
      bubble = 1'b1;
      pend_v_n = 1'b0;
      buf_pc_n = '0;
      buf_inst_n = '0;
      if (state == REQ && !ack) begin
        pend_pc_n = new_pc_i;
        state_n = DROP;
      end else if (state == DROP && !ack) begin
        pend_pc_n = new_pc_i;
      end else begin
        pc_n = new_pc_i;
        state_n = REQ;
      end
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (ack) begin
            pc_n = branch_flag_i ? branch_target_i : pend_v ? pend_pc : pc + ADDR_W'(4);
            pend_v_n = 1'b0;
            if (stall_i) begin
              buf_pc_n = pc;
              buf_inst_n = rom_data;
              state_n = BUF;
            end else begin
              if_pc_n = pc;
              if_inst_n = rom_data;
              if_valid_n = 1'b1;
            end
          end else begin
            if (branch_flag_i) begin
              pend_pc_n = branch_target_i;
              pend_v_n = 1'b1;
            end
            bubble = !stall_i;
          end
        end
        BUF: begin
          if (branch_flag_i) pc_n = branch_target_i;
          if (!stall_i) begin
            if_pc_n = buf_pc;
            if_inst_n = buf_inst;
            if_valid_n = 1'b1;
            state_n = REQ;
          end
        end
        default: begin
          bubble = !stall_i;
          if (ack) begin
            pc_n = pend_pc;
            pend_v_n = 1'b0;
            state_n = REQ;
          end
        end
      endcase
    end
    if (bubble) begin
      if_pc_n = '0;
      if_inst_n = '0;
      if_valid_n = 1'b0;
    end
  end
  // state register; reset abandons any request and clears the delivery slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend_pc <= '0;
      pend_v <= 1'b0;
      buf_pc <= '0;
      buf_inst <= '0;
      if_pc <= '0;
      if_inst <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend_pc <= pend_pc_n;
      pend_v <= pend_v_n;
      buf_pc <= buf_pc_n;
      buf_inst <= buf_inst_n;
      if_pc <= if_pc_n;
      if_inst <= if_inst_n;
      if_valid <= if_valid_n;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized checks of if_fetch against a fetch-stream reference model
module tb_if_fetch;
  logic clk = 1'b0, rst, stall_i, branch_flag_i, flush_i, rom_ack;
  logic [31:0] branch_target_i, new_pc_i, rom_data, rom_addr, if_pc, if_inst;
  logic rom_req, if_valid;
  int checks = 0, failures = 0, wcnt = 0, lat = 1;
  bit model_on = 0, pend_seen;
  logic [31:0] exp_fetch, pend_t;
  logic [31:0] dq[$];

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: ROM answers after lat cycles with ~addr, then the model checks what came out
  task automatic tick();
    logic p_ack, p_req, p_rst, p_br, p_st, p_v;
    logic [31:0] p_addr, p_bt, p_pc, p_inst, a;
    rom_ack = rom_req && (wcnt >= lat - 1);
    rom_data = rom_ack ? rom_addr ^ 32'hFFFF_FFFF : $urandom;
    p_ack = rom_ack; p_req = rom_req; p_rst = rst; p_br = branch_flag_i; p_st = stall_i;
    p_addr = rom_addr; p_bt = branch_target_i; p_pc = if_pc; p_inst = if_inst; p_v = if_valid;
    @(negedge clk);
    wcnt = (p_rst || !p_req || p_ack) ? 0 : wcnt + 1;
    if (model_on) begin
      if (p_ack) begin
        chk("fetch_addr", p_addr, exp_fetch);
        dq.push_back(p_addr);
        exp_fetch = p_br ? p_bt : pend_seen ? pend_t : p_addr + 32'd4;
        pend_seen = 0;
        lat = $urandom_range(1, 3);
      end else if (p_br && p_req) begin
        pend_seen = 1;
        pend_t = p_bt;
      end else if (p_br) begin
        exp_fetch = p_bt;
      end
      if (p_st) begin
        chk("hold_pc", if_pc, p_pc);
        chk("hold_inst", if_inst, p_inst);
        chk("hold_valid", 32'(if_valid), 32'(p_v));
      end else if (if_valid) begin
        if (dq.size() == 0) chk("dup_delivery", if_pc, 32'hDEAD_BEEF);
        else begin
          a = dq.pop_front();
          chk("deliv_pc", if_pc, a);
          chk("deliv_inst", if_inst, a ^ 32'hFFFF_FFFF);
        end
      end else begin
        chk("bubble_pc", if_pc, 32'h0);
        chk("bubble_inst", if_inst, 32'h0);
        chk("no_loss", 32'(dq.size()), 32'h0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; stall_i = 0; branch_flag_i = 0; flush_i = 0; lat = 1;
    tick();
    rst = 0;
    tick();
  endtask

  // reset, then zero-wait fetch until the request address reaches addr
  task automatic goto_addr(input logic [31:0] addr);
    int n = 0;
    do_reset();
    while (rom_addr !== addr && n < 64) begin tick(); n++; end
    chk("goto_reached", rom_addr, addr);
  endtask

  initial begin
    rst = 1; stall_i = 0; branch_flag_i = 0; flush_i = 0;
    branch_target_i = 0; new_pc_i = 0; rom_ack = 0; rom_data = 0;
    // reset values and zero-wait streaming
    tick();
    chk("rst_req", 32'(rom_req), 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_valid", 32'(if_valid), 0);
    rst = 0;
    tick();
    chk("req_rise", 32'(rom_req), 1);
    chk("first_addr", rom_addr, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zw_pc", if_pc, 32'(i * 4));
      chk("zw_inst", if_inst, 32'(i * 4) ^ 32'hFFFF_FFFF);
      chk("zw_valid", 32'(if_valid), 1);
    end
    // three-cycle ROM latency
    do_reset();
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        tick();
        chk("lat_addr_stable", rom_addr, 32'(k * 4));
        chk("lat_req", 32'(rom_req), 1);
        chk("lat_bubble_v", 32'(if_valid), 0);
        chk("lat_bubble_i", if_inst, 0);
      end
      tick();
      chk("lat_pc", if_pc, 32'(k * 4));
      chk("lat_valid", 32'(if_valid), 1);
    end
    // four-cycle stall arriving with the ack at 0x10
    goto_addr(32'h10);
    stall_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold_pc", if_pc, 32'hC);
      chk("stall_hold_v", 32'(if_valid), 1);
      chk("buf_noreq", 32'(rom_req), 0);
    end
    stall_i = 0;
    tick();
    chk("unstall_pc", if_pc, 32'h10);
    chk("unstall_inst", if_inst, 32'h10 ^ 32'hFFFF_FFFF);
    chk("unstall_addr", rom_addr, 32'h14);
    tick();
    chk("after_buf_pc", if_pc, 32'h14);
    // branch while 0x20 is pending, then branch coincident with ack
    for (int m = 0; m < 2; m++) begin
      goto_addr(32'h20);
      lat = 3;
      branch_target_i = 32'h100;
      branch_flag_i = (m == 0);
      tick();
      branch_flag_i = 0;
      tick();
      branch_flag_i = (m == 1);
      tick();
      branch_flag_i = 0;
      chk("br_delay_slot", if_pc, 32'h20);
      chk("br_target", rom_addr, 32'h100);
      lat = 1;
      tick();
      chk("br_deliv", if_pc, 32'h100);
    end
    // flush while the 0x40 request is outstanding, stalled downstream
    goto_addr(32'h40);
    lat = 3;
    stall_i = 1;
    tick();
    chk("pre_flush_hold", if_pc, 32'h3C);
    flush_i = 1; new_pc_i = 32'h180;
    tick();
    flush_i = 0; stall_i = 0;
    chk("flush_bubble", 32'(if_valid), 0);
    chk("drop_addr", rom_addr, 32'h40);
    tick();
    chk("drop_discard", 32'(if_valid), 0);
    chk("flush_addr", rom_addr, 32'h180);
    lat = 1;
    tick();
    chk("flush_deliv", if_pc, 32'h180);
    chk("flush_deliv_v", 32'(if_valid), 1);
    // flush while an instruction sits in the skid buffer
    goto_addr(32'h8);
    stall_i = 1;
    tick();
    flush_i = 1; new_pc_i = 32'h200;
    tick();
    flush_i = 0; stall_i = 0;
    chk("bufflush_v", 32'(if_valid), 0);
    chk("bufflush_addr", rom_addr, 32'h200);
    tick();
    chk("bufflush_deliv", if_pc, 32'h200);
    // reset mid-operation from the buffer and from a waiting request
    goto_addr(32'h10);
    stall_i = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; stall_i = 0;
    chk("midrst_req", 32'(rom_req), 0);
    chk("midrst_v", 32'(if_valid), 0);
    chk("midrst_pc", if_pc, 0);
    chk("midrst_addr", rom_addr, 0);
    tick();
    tick();
    chk("restart_pc", if_pc, 0);
    goto_addr(32'h8);
    lat = 3;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("waitrst_req", 32'(rom_req), 0);
    // pc wrap at the top of the address space
    do_reset();
    branch_flag_i = 1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 0;
    chk("wrap_top", rom_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_deliv", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", rom_addr, 0);
    // randomized latency, stalls and branches against the stream model
    rst = 1; stall_i = 0; branch_flag_i = 0; lat = 1;
    tick();
    rst = 0;
    exp_fetch = 0; pend_seen = 0; dq.delete(); model_on = 1;
    for (int i = 0; i < 600; i++) begin
      stall_i = ($urandom_range(0, 9) < 3);
      branch_flag_i = (i >= 2) && ($urandom_range(0, 9) < 2);
      branch_target_i = 32'($urandom_range(0, 255)) << 2;
      tick();
    end
    stall_i = 0; branch_flag_i = 0;
    for (int i = 0; i < 10; i++) tick();
    model_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
